pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 225 ++++++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//
// Two-stage elastic carry-lookahead adder/subtractor.
//   Stage 1 conditions operand B for subtraction, forms per-bit
//   propagate/generate terms and per-group lookahead (PG/GG) terms.
//   Stage 2 resolves group carry-ins by lookahead over PG/GG (no ripple
//   between groups), resolves in-group carries by lookahead, and registers
//   the result with its flags.
//
// Parameters
//   WIDTH  operand/result width in bits
//   GROUP  bits per lookahead group; WIDTH must be a multiple of GROUP
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears control and data)
//   in_valid   operand set presented
//   in_ready   stage 1 can accept an operand set
//   a, b       operands
//   cin        carry in (ignored when sub=1)
//   sub        0: a + b + cin, 1: a - b
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of MSB (for sub=1: 1 means no borrow)
//   overflow   signed overflow
//   zero       sum == 0
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  // Carry out of the low n positions of (g, p) with carry-in c, written as a
  // flat sum of products: g[i] & p[i+1] & ... & p[n-1], plus the all-propagate
  // term with c. The loops unroll into two-level logic, not a ripple chain.
  function automatic logic la_carry(input logic [WIDTH-1:0] g,
                                    input logic [WIDTH-1:0] p,
                                    input logic             c,
                                    input int               n);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < n) begin
        term = g[i];
        for (int j = i + 1; j < WIDTH; j++) begin
          if (j < n) term = term & p[j];
        end
        acc = acc | term;
      end
    end
    term = c;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < n) term = term & p[j];
    end
    return acc | term;
  endfunction

  // Handshake control
  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic in_fire;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // ---- Stage 1: operand conditioning and group lookahead terms ----
  logic [WIDTH-1:0] beff_c;
  logic [WIDTH-1:0] x_c;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic             c0_c;
  logic [NG-1:0]    pg_c;
  logic [NG-1:0]    gg_c;

  always_comb begin : stage1_comb
    logic [WIDTH-1:0] gx;
    logic [WIDTH-1:0] px;
    beff_c = sub ? ~b : b;
    c0_c   = sub ? 1'b1 : cin;
    x_c    = a ^ beff_c;
    p_c    = a | beff_c;
    g_c    = a & beff_c;
    pg_c   = '0;
    gg_c   = '0;
    for (int k = 0; k < NG; k++) begin
      gx = '0;
      px = '0;
      gx[GROUP-1:0] = g_c[k*GROUP +: GROUP];
      px[GROUP-1:0] = p_c[k*GROUP +: GROUP];
      pg_c[k] = &p_c[k*GROUP +: GROUP];
      gg_c[k] = la_carry(gx, px, 1'b0, GROUP);
    end
  end

  logic [WIDTH-1:0] x_p1;
  logic [WIDTH-1:0] p_p1;
  logic [WIDTH-1:0] g_p1;
  logic             c0_p1;
  logic [NG-1:0]    pg_p1;
  logic [NG-1:0]    gg_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1  <= '0;
      p_p1  <= '0;
      g_p1  <= '0;
      c0_p1 <= 1'b0;
      pg_p1 <= '0;
      gg_p1 <= '0;
    end else if (in_fire) begin
      x_p1  <= x_c;
      p_p1  <= p_c;
      g_p1  <= g_c;
      c0_p1 <= c0_c;
      pg_p1 <= pg_c;
      gg_p1 <= gg_c;
    end
  end

  // ---- Stage 2: carry resolution, sum and flags ----
  // grp_cin[k] is the carry into group k; grp_cin[NG] is the carry out.
  logic [NG:0]      grp_cin;
  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic             zero_c;

  always_comb begin : stage2_comb
    logic [WIDTH-1:0] gge;
    logic [WIDTH-1:0] pge;
    logic [WIDTH-1:0] gx;
    logic [WIDTH-1:0] px;
    gge = '0;
    pge = '0;
    gge[NG-1:0] = gg_p1;
    pge[NG-1:0] = pg_p1;
    grp_cin = '0;
    for (int k = 0; k <= NG; k++) begin
      grp_cin[k] = la_carry(gge, pge, c0_p1, k);
    end
    carry_c = '0;
    for (int k = 0; k < NG; k++) begin
      gx = '0;
      px = '0;
      gx[GROUP-1:0] = g_p1[k*GROUP +: GROUP];
      px[GROUP-1:0] = p_p1[k*GROUP +: GROUP];
      for (int i = 0; i < GROUP; i++) begin
        carry_c[k*GROUP+i] = la_carry(gx, px, grp_cin[k], i);
      end
    end
    sum_c  = x_p1 ^ carry_c;
    cout_c = grp_cin[NG];
    ovf_c  = carry_c[WIDTH-1] ^ cout_c;
    zero_c = ~|sum_c;
  end

  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2;
  logic             ovf_p2;
  logic             zero_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
    end
  end

  // Data only moves when a real result advances, so a stalled or empty
  // stage 2 keeps its outputs steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
    end else if (s2_load && s1_valid) begin
      sum_p2  <= sum_c;
      cout_p2 <= cout_c;
      ovf_p2  <= ovf_c;
      zero_p2 <= zero_c;
    end
  end

  assign out_valid = s2_valid;
  assign sum       = sum_p2;
  assign cout      = cout_p2;
  assign overflow  = ovf_p2;
  assign zero      = zero_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Scoreboard bench for pipelined_cla_adder (WIDTH=32, GROUP=4). Expected
// results come from a plain arithmetic model, queued when an input transfer
// is seen and compared when an output transfer is seen. Inputs change #1
// after the rising edge; handshakes are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipelined_cla_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  logic        rnd_ready;
  logic        rnd_bit;
  logic        fixed_ready;

  int          n_tests;
  int          n_fail;
  int          n_sent;
  int          n_out;

  logic [34:0] sb_q[$];

  assign out_ready = rnd_ready ? rnd_bit : fixed_ready;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed as {cout, overflow, zero, sum}.
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mcin, input logic msub);
    logic [31:0] be;
    logic [32:0] t;
    logic        ov;
    be = msub ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, be} + {32'd0, (msub ? 1'b1 : mcin)};
    ov = (ma[31] == be[31]) && (t[31] != ma[31]);
    return {t[32], ov, (t[31:0] == 32'd0), t[31:0]};
  endfunction

  // Output monitor: scoreboard compare on transfer, stability while stalled.
  initial begin
    logic        held_vld;
    logic [34:0] held;
    logic [34:0] exp;
    held_vld = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld && out_valid)
          chk("stall_hold", {cout, overflow, zero, sum}, held);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'(sb_q.size()), 1);
          end else begin
            exp = sb_q.pop_front();
            chk("result", {cout, overflow, zero, sum}, exp);
          end
          n_out++;
          held_vld = 1'b0;
        end else if (out_valid) begin
          held_vld = 1'b1;
          held     = {cout, overflow, zero, sum};
        end else begin
          held_vld = 1'b0;
        end
      end
    end
  end

  // Present one operand set and hold it until it is transferred.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic tcin, input logic tsub);
    bit fired;
    fired    = 1'b0;
    a        = ta;
    b        = tb;
    cin      = tcin;
    sub      = tsub;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(ta, tb, tcin, tsub));
        n_sent++;
        fired = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!fired) chk("send_timeout", 64'(fired), 1);
    in_valid = 1'b0;
  endtask

  // From an empty pipeline with out_ready=1: check latency and fixed values.
  task automatic send_see(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tsub, input logic [34:0] exp);
    send(ta, tb, tcin, tsub);
    chk({tag, "_vld_e1"}, 64'(out_valid), 0);
    @(posedge clk);
    #1;
    chk({tag, "_vld_e2"}, 64'(out_valid), 1);
    chk({tag, "_res"}, {cout, overflow, zero, sum}, exp);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sb_q.size()), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    n_tests     = 0;
    n_fail      = 0;
    n_sent      = 0;
    n_out       = 0;
    rnd_ready   = 1'b0;
    fixed_ready = 1'b1;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    rst_n       = 1'b0;

    #2;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_cout", 64'(cout), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_zero", 64'(zero), 0);
    chk("rst_in_ready", 64'(in_ready), 1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Carry out of all ones into zero.
    send_see("wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0,
             {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    // Signed overflow, then subtraction with borrow.
    send_see("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    send_see("sub", 32'd5, 32'd7, 1'b0, 1'b1,
             {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
    // No borrow and carry-in use.
    send_see("nobrw", 32'd9, 32'd9, 1'b1, 1'b1,
             {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    send_see("cin", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0,
             {1'b0, 1'b0, 1'b0, 32'h0001_0000});
    drain(50);

    // Backpressure: two captures fill the pipe, the third must wait.
    fixed_ready = 1'b0;
    send(32'd1, 32'd1, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0);
    a        = 32'd3;
    b        = 32'd3;
    cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 0);
      chk("full_out_valid", 64'(out_valid), 1);
      chk("full_head", 64'(sum), 2);
      @(posedge clk);
      #1;
    end
    fixed_ready = 1'b1;
    send(32'd3, 32'd3, 1'b0, 1'b0);
    drain(50);

    // Random stream with random backpressure and input gaps.
    base      = n_out;
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain(5000);
    chk("stream_count", 64'(n_out - base), 1000);
    rnd_ready = 1'b0;

    // Asynchronous reset with both stages full.
    fixed_ready = 1'b0;
    send(32'd11, 32'd22, 1'b0, 1'b0);
    send(32'd33, 32'd44, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 64'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_sum", 64'(sum), 0);
    chk("arst_in_ready", 64'(in_ready), 1);
    sb_q.delete();
    base = n_out;
    @(posedge clk);
    #1 rst_n = 1'b1;
    fixed_ready = 1'b1;
    send(32'd9, 32'd10, 1'b0, 1'b0);
    drain(50);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_count", 64'(n_out - base), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
